// File: rtl/arb_pkg.sv
// Shared sizing helpers and types for the single-master, multi-slave split-bus arbiter.
package arb_pkg;

    function automatic int clog2_sel(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 5; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int NSLAVES_DEF   = 4;
    localparam int MAX_OUTST_DEF = 4;
    localparam int SEL_W         = clog2_sel(NSLAVES_DEF);
    localparam int OUTST_W       = clog2_sel(MAX_OUTST_DEF) + 1;

    typedef logic [SEL_W-1:0] slv_idx_t;

endpackage

// File: rtl/arb_idx_fifo.sv
// In-order tracking FIFO of slave indices for outstanding reads; keeps a copy of the newest entry.
module arb_idx_fifo
    import arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic [W-1:0]  tail_o,
    output logic [PW:0]   cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   cnt_r;
    logic [W-1:0]  tail_r;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_o    = (cnt_r == (PW+1)'(DEPTH));
    assign empty_o   = (cnt_r == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign head_o    = mem_r[rd_ptr_r];
    assign tail_o    = tail_r;
    assign cnt_o     = cnt_r;

    // Pointer, count and storage update.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            tail_r   <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din_i;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
                tail_r          <= din_i;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/arb_1mns.sv
// One master to NSLAVES slaves with in-order pipelined reads.
// Optional stray-response counter port err_cnt_o enabled by ARB_1MNS_ERRCNT_EN.
module arb_1mns
    import arb_pkg::*;
#(
    parameter int NSLAVES   = 4,
    parameter int SEL_MSB   = 31,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m_req_i,
    input  logic                  m_we_i,
    input  logic [31:0]           m_addr_i,
    input  logic [3:0]            m_be_i,
    input  logic [31:0]           m_wdata_i,
    output logic                  m_ack_o,
    output logic                  m_resp_o,
    output logic [31:0]           m_rdata_o,
    output logic [NSLAVES-1:0]    s_req_o,
    output logic [NSLAVES-1:0]    s_we_o,
    output logic [32*NSLAVES-1:0] s_addr_o,
    output logic [4*NSLAVES-1:0]  s_be_o,
    output logic [32*NSLAVES-1:0] s_wdata_o,
    input  logic [NSLAVES-1:0]    s_ack_i,
    input  logic [NSLAVES-1:0]    s_resp_i,
    input  logic [32*NSLAVES-1:0] s_rdata_i
`ifdef ARB_1MNS_ERRCNT_EN
    ,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int SW = clog2_sel(NSLAVES);
    localparam int PW = clog2_sel(MAX_OUTST);

    logic [SW-1:0] sel_s;
    logic [SW-1:0] head_s;
    logic [SW-1:0] tail_s;
    logic [PW:0]   cnt_s;
    logic          full_s;
    logic          empty_s;
    logic          fwd_s;
    logic          push_s;
    logic          pop_s;

    assign sel_s  = m_addr_i[SEL_MSB -: SW];
    assign push_s = m_req_i & ~m_we_i & m_ack_o;
    assign pop_s  = m_resp_o;

    // A request may only join the slave already holding outstanding reads.
    always_comb begin
        fwd_s = 1'b0;
        if (m_req_i && !full_s && (empty_s || (sel_s == tail_s))) begin
            fwd_s = 1'b1;
        end else begin
            fwd_s = 1'b0;
        end
    end

    // Request routing to the selected slave.
    always_comb begin
        s_req_o   = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        m_ack_o   = 1'b0;
        if (fwd_s) begin
            s_req_o[sel_s]                  = 1'b1;
            s_we_o[sel_s]                   = m_we_i;
            s_addr_o[32*int'(sel_s) +: 32]  = m_addr_i;
            s_be_o[4*int'(sel_s) +: 4]      = m_be_i;
            s_wdata_o[32*int'(sel_s) +: 32] = m_wdata_i;
            m_ack_o                         = s_ack_i[sel_s];
        end else begin
            m_ack_o = 1'b0;
        end
    end

    // Only the oldest outstanding slave's response reaches the master.
    always_comb begin
        m_resp_o  = 1'b0;
        m_rdata_o = 32'h0;
        if (cnt_s != '0) begin
            m_resp_o  = s_resp_i[head_s];
            m_rdata_o = s_rdata_i[32*int'(head_s) +: 32];
        end else begin
            m_resp_o  = 1'b0;
            m_rdata_o = 32'h0;
        end
    end

    arb_idx_fifo #(
        .W     (SW),
        .DEPTH (MAX_OUTST),
        .PW    (PW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (sel_s),
        .head_o  (head_s),
        .tail_o  (tail_s),
        .cnt_o   (cnt_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

`ifdef ARB_1MNS_ERRCNT_EN
    localparam logic [NSLAVES-1:0] ONE_HOT0 = {{(NSLAVES-1){1'b0}}, 1'b1};

    logic        stray_s;
    logic [15:0] err_cnt_r;

    // Any response not coming from the current head is stray.
    always_comb begin
        stray_s = 1'b0;
        if (empty_s) begin
            stray_s = |s_resp_i;
        end else begin
            stray_s = |(s_resp_i & ~(ONE_HOT0 << head_s));
        end
    end

    // Saturating stray-response counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_cnt_r <= 16'h0000;
        end else if (stray_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'h0001;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_arb_1mns.sv
// Randomized bench for arb_1mns against a queue-based model of outstanding reads and slave timing.
module tb_arb_1mns;

    localparam int NS   = 4;
    localparam int MAXO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m_req_i;
    logic          m_we_i;
    logic [31:0]   m_addr_i;
    logic [3:0]    m_be_i;
    logic [31:0]   m_wdata_i;
    logic          m_ack_o;
    logic          m_resp_o;
    logic [31:0]   m_rdata_o;
    logic [3:0]    s_req_o;
    logic [3:0]    s_we_o;
    logic [127:0]  s_addr_o;
    logic [15:0]   s_be_o;
    logic [127:0]  s_wdata_o;
    logic [3:0]    s_ack_i;
    logic [3:0]    s_resp_i;
    logic [127:0]  s_rdata_i;
`ifdef ARB_1MNS_ERRCNT_EN
    logic [15:0]   err_cnt_o;
`endif

    arb_1mns #(.NSLAVES(NS), .SEL_MSB(31), .MAX_OUTST(MAXO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .m_req_i   (m_req_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_be_i    (m_be_i),
        .m_wdata_i (m_wdata_i),
        .m_ack_o   (m_ack_o),
        .m_resp_o  (m_resp_o),
        .m_rdata_o (m_rdata_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_be_o    (s_be_o),
        .s_wdata_o (s_wdata_o),
        .s_ack_i   (s_ack_i),
        .s_resp_i  (s_resp_i),
        .s_rdata_i (s_rdata_i)
`ifdef ARB_1MNS_ERRCNT_EN
        ,
        .err_cnt_o (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          slv;
        logic [31:0] data;
        int          rdy;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          q[$];
    pend_t       pend[$];
    logic [15:0] err_m  = 16'h0;
    bit          drove_real = 1'b0;
    int          last_sel = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Evaluate one cycle against the model, then advance model state at the clock edge.
    task automatic step();
        int cnt, head, tail, sel;
        bit fwd, ack, resp, stray;
        logic [3:0]   e_req, e_we;
        logic [127:0] e_addr, e_wd;
        logic [15:0]  e_be;
        logic [31:0]  e_rd;
        #2;
        cnt  = q.size();
        head = (cnt > 0) ? q[0] : 0;
        tail = (cnt > 0) ? q[cnt-1] : 0;
        sel  = int'(m_addr_i[31:30]);
        fwd  = m_req_i && (cnt < MAXO) && (cnt == 0 || sel == tail);
        e_req = 4'h0; e_we = 4'h0; e_addr = '0; e_wd = '0; e_be = 16'h0;
        if (fwd) begin
            e_req[sel] = 1'b1;
            e_we[sel]  = m_we_i;
            e_addr[32*sel +: 32] = m_addr_i;
            e_wd[32*sel +: 32]   = m_wdata_i;
            e_be[4*sel +: 4]     = m_be_i;
        end
        ack  = fwd && s_ack_i[sel];
        resp = (cnt > 0) && s_resp_i[head];
        e_rd = (cnt > 0) ? s_rdata_i[32*head +: 32] : 32'h0;
        stray = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (s_resp_i[k] && (cnt == 0 || k != head)) stray = 1'b1;
        end
        check_eq("s_req", s_req_o, e_req);
        check_eq("s_we", s_we_o, e_we);
        check_eq("s_addr", s_addr_o, e_addr);
        check_eq("s_be", s_be_o, e_be);
        check_eq("s_wdata", s_wdata_o, e_wd);
        check_eq("m_ack", m_ack_o, ack);
        check_eq("m_resp", m_resp_o, resp);
        check_eq("m_rdata", m_rdata_o, e_rd);
        if (drove_real) check_eq("real_resp_taken", m_resp_o, 1'b1);
`ifdef ARB_1MNS_ERRCNT_EN
        check_eq("err_cnt", err_cnt_o, err_m);
`endif
        @(posedge clk_i);
        if (!rst_i) begin
            q.delete();
            err_m = 16'h0;
        end else begin
            if (resp) void'(q.pop_front());
            if (ack && !m_we_i) begin
                q.push_back(sel);
                pend.push_back('{sel, $urandom, cyc + 1 + int'($urandom_range(0, 3))});
            end
            if (drove_real) void'(pend.pop_front());
            if (stray && err_m != 16'hFFFF) err_m = err_m + 16'h1;
        end
        drove_real = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        m_req_i = 1'b0; m_we_i = 1'b0; m_addr_i = 32'h0; m_be_i = 4'h0;
        m_wdata_i = 32'h0; s_ack_i = 4'h0; s_resp_i = 4'h0; s_rdata_i = '0;
        drove_real = 1'b0;
    endtask

    // Reset, then replay any responses still in flight as late arrivals.
    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        while (pend.size() > 0) begin
            idle_inputs();
            s_resp_i[pend[0].slv] = 1'b1;
            s_rdata_i[32*pend[0].slv +: 32] = pend[0].data;
            void'(pend.pop_front());
            step();
        end
        idle_inputs();
    endtask

    task automatic gen_random();
        int sel, k;
        idle_inputs();
        m_req_i = ($urandom_range(0, 3) != 0);
        m_we_i  = ($urandom_range(0, 3) == 0);
        sel = ($urandom_range(0, 9) < 7) ? last_sel : int'($urandom_range(0, 3));
        last_sel = sel;
        m_addr_i = {2'(sel), 30'($urandom)};
        m_be_i = 4'($urandom);
        m_wdata_i = $urandom;
        s_ack_i = 4'($urandom);
        for (int j = 0; j < NS; j++) s_rdata_i[32*j +: 32] = $urandom;
        if (pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(0, 2) != 0) begin
            s_resp_i[pend[0].slv] = 1'b1;
            s_rdata_i[32*pend[0].slv +: 32] = pend[0].data;
            drove_real = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) begin
            k = int'($urandom_range(0, 3));
            if (!(q.size() > 0 && k == q[0])) s_resp_i[k] = 1'b1;
        end
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        do_reset();
        step();

        // Write to slave 1: forwarded, acked, nothing tracked.
        m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h4000_0010;
        m_be_i = 4'hF; m_wdata_i = 32'h1234_5678; s_ack_i = 4'b0010;
        #2;
        check_eq("wr_s_req", s_req_o, 4'b0010);
        check_eq("wr_s_addr1", s_addr_o[63:32], 32'h4000_0010);
        check_eq("wr_m_ack", m_ack_o, 1'b1);
        step();

        // Read to slave 0, then a stray response from slave 3.
        idle_inputs();
        m_req_i = 1'b1; m_addr_i = 32'h0000_0100; s_ack_i = 4'b0001;
        step();
        idle_inputs();
        s_resp_i = 4'b1000;
        s_rdata_i[127:96] = 32'hDEAD_BEEF;
        step();
        last_sel = 0;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            gen_random();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_1mns.md
Name: arb_1mns

Overview:
- Parametrised successor of the single-master, two-slave split-bus arbiter.
- Routes one MemSplit32-style master to NSLAVES slaves, decoding the target slave from an address bit field.
- Allows up to MAX_OUTST outstanding reads, tracked in order by an index FIFO, so back-to-back reads to one slave pipeline without stalling.
- Sits between a core data/instruction port and the tile's memory/IO slaves.

Parameters:
- NSLAVES, 4, number of slave ports; power of two, 2..16.
- SEL_MSB, 31, MSB of the address field holding the slave index; field is addr[SEL_MSB -: log2(NSLAVES)].
- MAX_OUTST, 4, maximum outstanding reads; power of two, 1..16.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- m_req_i  in  1  master request.
- m_we_i  in  1  master write enable.
- m_addr_i  in  32  master address.
- m_be_i  in  4  master byte enables.
- m_wdata_i  in  32  master write data.
- m_ack_o  out  1  request accepted.
- m_resp_o  out  1  read response valid.
- m_rdata_o  out  32  read data.
- s_req_o  out  NSLAVES  per-slave request.
- s_we_o  out  NSLAVES  per-slave write enable.
- s_addr_o  out  32*NSLAVES  per-slave address, packed; slave k occupies [32k+31:32k].
- s_be_o  out  4*NSLAVES  per-slave byte enables, packed.
- s_wdata_o  out  32*NSLAVES  per-slave write data, packed.
- s_ack_i  in  NSLAVES  per-slave accept.
- s_resp_i  in  NSLAVES  per-slave read response.
- s_rdata_i  in  32*NSLAVES  per-slave read data, packed.

Behaviour:
- Reset value of every output is 0, combinationally, whenever the FIFO is empty and m_req_i=0. Reset clears FIFO pointers and count.
- Decode: sel = m_addr_i[SEL_MSB -: log2(NSLAVES)].
- Tracking FIFO: depth MAX_OUTST, entries are slave indices. cnt is 0..MAX_OUTST. head = oldest outstanding slave, tail = newest.
- Forwarding condition: fwd = m_req_i & (cnt < MAX_OUTST) & (cnt==0 | sel==tail).
  - When fwd=1, slave sel gets req/we/addr/be/wdata copied from the master, and m_ack_o = s_ack_i[sel].
  - All other slaves see zeros. When fwd=0, all s_*_o are 0 and m_ack_o=0.
- Same-slave rule: a request (read or write) to a slave other than tail stalls until the FIFO drains. This preserves response ordering and write-after-read ordering.
- Push: m_req_i & ~m_we_i & m_ack_o pushes sel. Writes never push and produce no response.
- Response path, combinational, zero added latency:
  - If cnt>0: m_resp_o = s_resp_i[head], m_rdata_o = s_rdata_i[head].
  - Otherwise m_resp_o=0, m_rdata_o=0.
  - Pop when m_resp_o=1.
- Simultaneous push and pop: cnt unchanged, both pointers advance.
- Full (cnt==MAX_OUTST): no push. A pop in the same cycle does not unblock that cycle's request; the request waits one cycle (no full-to-push bypass).
- Responses from any slave other than head are ignored and never reach the master.
- Pointers wrap modulo MAX_OUTST. cnt never exceeds MAX_OUTST and never underflows.
- Reset mid-operation: outstanding entries are discarded. Responses arriving after reset are ignored, because cnt==0.
- Slave requirement: each slave returns read responses in request order, at least one cycle after its ack.

Optional Feature:
- Macro: ARB_1MNS_ERRCNT_EN.
- With the macro defined:
  - Extra port err_cnt_o  out  16, a saturating count of stray responses. A stray response is any s_resp_i[k]=1 with k!=head, or any response while cnt==0.
  - err_cnt_o is cleared by reset and holds at 16'hFFFF.
- Without the macro: port absent, no counter logic.

Decomposition:
- Package arb_pkg:
  - function clog2_sel(NSLAVES).
  - typedef slv_idx_t, a logic vector of log2(NSLAVES) bits.
  - constant SEL_W.
  - localparam OUTST_W.
- Sub-module arb_idx_fifo: parametrised-width sync FIFO with push, pop, head, tail, cnt and full/empty outputs, reset active-low synchronous. It is instantiated once.

Test Plan:
- Reset, then idle with rst_i=0 for 2 cycles, then release with no requests -> all outputs 0, cnt 0.
- Write to 0x4000_0010 (NSLAVES=4, SEL_MSB=31 -> slave 1) with s_ack_i[1]=1 -> s_req_o=4'b0010, s_addr for slave 1 is 0x4000_0010, m_ack_o=1, no FIFO push.
- Four back-to-back reads to slave 2, acked every cycle, with responses 0xA0..0xA3 arriving 3 cycles later -> all four acked without stall. m_rdata_o sequence is A0,A1,A2,A3. A fifth read issued while full stalls (m_ack_o=0) until the first response.
- Read to slave 0 outstanding, then read to slave 3 -> slave-3 request held (s_req_o=0) until slave 0 responds. Next cycle s_req_o=4'b1000.
- Stray response s_resp_i[3]=1 while head=0 -> m_resp_o=0, FIFO unchanged. With ARB_1MNS_ERRCNT_EN, err_cnt_o increments 0->1.
- Reset asserted with 2 reads outstanding, then a late s_resp_i[2] -> m_resp_o stays 0, cnt=0.
